// File: rtl/uart_pkg.sv
// Shared UART constants and the byte type used by the RX path.
//   UART_DATA_W        byte width of the RX deserialiser
//   UART_RX_FIFO_DEPTH default receive buffer depth
//   uart_byte_t        one received byte
package uart_pkg;
  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock circular buffer with a first-word-fall-through read port.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset (pointers only; storage is not reset)
//   i_push_req        write request; accepted when not full, or when full with a pop in the same cycle
//   i_wr_data         data written on an accepted push
//   i_rd_en           pop request; ignored while empty
//   o_rd_data         head entry, combinational; don't-care while empty
//   o_empty, o_full   occupancy flags
//   o_count           occupancy 0..DEPTH
import uart_pkg::*;

module sync_fifo #(
  parameter int DATA  = UART_DATA_W,
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push_req,
  input  logic [DATA-1:0] i_wr_data,
  input  logic            i_rd_en,
  output logic [DATA-1:0] o_rd_data,
  output logic            o_empty,
  output logic            o_full,
  output logic [AW:0]     o_count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // One extra MSB on each pointer distinguishes full from empty when the index bits match.
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [DATA-1:0] mem [DEPTH];
  logic            pop, push;

  assign o_empty   = (wr_ptr == rd_ptr);
  assign o_full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
  assign o_count   = wr_ptr - rd_ptr;
  assign o_rd_data = mem[rd_ptr[AW-1:0]];

  assign pop  = i_rd_en & ~o_empty;
  // A pop frees the head slot this cycle, so a full FIFO can still take the push.
  assign push = i_push_req & (~o_full | pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART RX deserialiser.
// Pushes one byte per rising edge of i_rx_ready into a sync_fifo, flags overrun when a
// byte arrives with the FIFO full and no pop to make room.
// Optional feature macro UART_RX_FIFO_OVR_COUNT_EN: adds an 8-bit saturating dropped-byte
// counter on o_ovr_count; without it o_ovr_count is tied to 0.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   i_rx_data         received byte, stable while i_rx_ready is high
//   i_rx_ready        byte-ready level; 0->1 marks a new byte
//   i_rd_en           pop request
//   o_rd_data         head entry, valid while o_empty=0
//   o_empty, o_full   occupancy flags
//   o_count           occupancy 0..DEPTH
//   o_overrun         sticky overrun flag
//   i_clr_overrun     clears o_overrun and the dropped-byte counter
//   o_ovr_count       dropped-byte count (0 when the counter is not built)
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int DATA  = UART_DATA_W,
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [DATA-1:0] i_rx_data,
  input  logic            i_rx_ready,
  input  logic            i_rd_en,
  output logic [DATA-1:0] o_rd_data,
  output logic            o_empty,
  output logic            o_full,
  output logic [AW:0]     o_count,
  output logic            o_overrun,
  input  logic            i_clr_overrun,
  output logic [7:0]      o_ovr_count
);

  logic rdy_q, push_req, drop;

  // rdy_q resets high so a ready level already asserted at reset release is not a new byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_q <= 1'b1;
    else          rdy_q <= i_rx_ready;
  end

  assign push_req = i_rx_ready & ~rdy_q;
  // Full is never empty, so i_rd_en alone means a real pop is making room.
  assign drop     = push_req & o_full & ~i_rd_en;

  sync_fifo #(.DATA(DATA), .DEPTH(DEPTH)) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push_req (push_req),
    .i_wr_data  (i_rx_data),
    .i_rd_en    (i_rd_en),
    .o_rd_data  (o_rd_data),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_count    (o_count)
  );

  // Set has priority over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           o_overrun <= 1'b0;
    else if (drop)          o_overrun <= 1'b1;
    else if (i_clr_overrun) o_overrun <= 1'b0;
  end

`ifdef UART_RX_FIFO_OVR_COUNT_EN
  logic [7:0] ovr_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovr_cnt <= 8'd0;
    end else if (drop) begin
      if (i_clr_overrun)         ovr_cnt <= 8'd1;
      else if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end else if (i_clr_overrun) begin
      ovr_cnt <= 8'd0;
    end
  end

  assign o_ovr_count = ovr_cnt;
`else
  assign o_ovr_count = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
import uart_pkg::*;

module tb_uart_rx_fifo;
  localparam int DEPTH = UART_RX_FIFO_DEPTH;
  localparam int AW    = $clog2(DEPTH);
`ifdef UART_RX_FIFO_OVR_COUNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic            i_clk, i_rst_n;
  uart_byte_t      i_rx_data;
  logic            i_rx_ready, i_rd_en, i_clr_overrun;
  uart_byte_t      o_rd_data;
  logic            o_empty, o_full, o_overrun;
  logic [AW:0]     o_count;
  logic [7:0]      o_ovr_count;

  int n_tests = 0, n_fail = 0;

  // Reference model: a queue of bytes plus the observable flags.
  uart_byte_t q[$];
  bit         m_prev;
  bit         m_ovr;
  int         m_cnt;

  uart_rx_fifo dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_ready(i_rx_ready),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_empty(o_empty), .o_full(o_full),
    .o_count(o_count), .o_overrun(o_overrun), .i_clr_overrun(i_clr_overrun),
    .o_ovr_count(o_ovr_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic model_reset();
    q.delete();
    m_prev = 1'b1;
    m_ovr  = 1'b0;
    m_cnt  = 0;
  endtask

  // Drive one clock cycle of inputs, advance the model, return #1 after the edge.
  task automatic cyc(input bit rdy, input bit rd, input uart_byte_t d, input bit clr);
    bit pop, preq, drp;
    i_rx_ready = rdy; i_rd_en = rd; i_rx_data = d; i_clr_overrun = clr;
    pop  = rd && (q.size() > 0);
    preq = rdy && !m_prev;
    drp  = preq && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (preq && !drp) q.push_back(d);
    if (drp) m_ovr = 1'b1; else if (clr) m_ovr = 1'b0;
    if (drp) m_cnt = clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    else if (clr) m_cnt = 0;
    m_prev = rdy;
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse(input uart_byte_t d);
    cyc(1'b1, 1'b0, d, 1'b0);
    cyc(1'b0, 1'b0, d, 1'b0);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_rx_ready = 1'b1; i_rd_en = 1'b0; i_rx_data = 8'h00; i_clr_overrun = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 8'hEE, 1'b0);
    n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", o_empty); end
    n_tests++; if (o_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", o_count); end
    n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", o_full); end
    n_tests++; if (o_overrun !== 1'b0 || o_ovr_count !== 8'd0) begin n_fail++; $display("FAIL reset_ovr got %b/%0d exp 0/0", o_overrun, o_ovr_count); end
  endtask

  task automatic test_basic();
    uart_byte_t exp_b;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    pulse(8'h41); pulse(8'h42); pulse(8'h43);
    n_tests++; if (o_count !== 5'd3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", o_count); end
    for (int i = 0; i < 3; i++) begin
      exp_b = 8'h41 + 8'(i);
      n_tests++; if (o_rd_data !== exp_b) begin n_fail++; $display("FAIL basic_read%0d got %h exp %h", i, o_rd_data, exp_b); end
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
    end
    n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL basic_drained got %b exp 1", o_empty); end
  endtask

  task automatic test_hold();
    repeat (50) cyc(1'b1, 1'b0, 8'h55, 1'b0);
    n_tests++; if (o_count !== 5'd1 || o_rd_data !== 8'h55) begin n_fail++; $display("FAIL hold_one got cnt %0d data %h exp 1/55", o_count, o_rd_data); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL hold_drain got %b exp 1", o_empty); end
  endtask

  task automatic test_overrun();
    uart_byte_t exp_b;
    for (int i = 0; i < DEPTH; i++) pulse(8'(i));
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    n_tests++; if (o_full !== 1'b1 || o_count !== 5'd16) begin n_fail++; $display("FAIL ovr_full got %b/%0d exp 1/16", o_full, o_count); end
    n_tests++; if (o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b exp 1", o_overrun); end
    n_tests++; if (o_ovr_count !== (OVR_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL ovr_count got %0d exp %0d", o_ovr_count, OVR_EN ? 1 : 0); end
    n_tests++; if (o_rd_data !== 8'h00) begin n_fail++; $display("FAIL ovr_head got %h exp 00", o_rd_data); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    n_tests++; if (o_overrun !== 1'b0 || o_ovr_count !== 8'd0) begin n_fail++; $display("FAIL ovr_clear got %b/%0d exp 0/0", o_overrun, o_ovr_count); end
    // Full, push and pop together: both land, no overrun.
    cyc(1'b1, 1'b1, 8'hBB, 1'b0);
    n_tests++; if (o_count !== 5'd16 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL fullpp got cnt %0d ovr %b exp 16/0", o_count, o_overrun); end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      exp_b = 8'(i);
      n_tests++; if (o_rd_data !== exp_b) begin n_fail++; $display("FAIL fullpp_read%0d got %h exp %h", i, o_rd_data, exp_b); end
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
    end
    n_tests++; if (o_rd_data !== 8'hBB || o_count !== 5'd1) begin n_fail++; $display("FAIL fullpp_last got %h/%0d exp BB/1", o_rd_data, o_count); end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    // rd_en while empty must do nothing.
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    n_tests++; if (o_empty !== 1'b1 || o_count !== '0) begin n_fail++; $display("FAIL empty_rd got %b/%0d exp 1/0", o_empty, o_count); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < DEPTH; i++) pulse(8'h10 + 8'(i));
    for (int i = 0; i < 260; i++) pulse(8'hCC);
    n_tests++; if (o_ovr_count !== (OVR_EN ? 8'd255 : 8'd0) || o_overrun !== 1'b1) begin n_fail++; $display("FAIL sat_count got %0d/%b exp %0d/1", o_ovr_count, o_overrun, OVR_EN ? 255 : 0); end
    cyc(1'b1, 1'b0, 8'hCD, 1'b1);
    n_tests++; if (o_ovr_count !== (OVR_EN ? 8'd1 : 8'd0) || o_overrun !== 1'b1) begin n_fail++; $display("FAIL set_wins got %0d/%b exp %0d/1", o_ovr_count, o_overrun, OVR_EN ? 1 : 0); end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (o_rd_data !== q[0]) begin n_fail++; $display("FAIL sat_drain%0d got %h exp %h", i, o_rd_data, q[0]); end
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
    end
    n_tests++; if (o_empty !== 1'b1 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL sat_end got %b/%b exp 1/0", o_empty, o_overrun); end
  endtask

  task automatic test_wrap();
    uart_byte_t d;
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      cyc(1'b1, 1'b0, d, 1'b0);
      if (o_count !== 5'd1 || o_rd_data !== d) bad++;
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      if (o_count !== 5'd0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wrap got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_random();
    int bad = 0;
    bit rd;
    for (int i = 0; i < 600; i++) begin
      rd = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(1'($urandom_range(0, 1)), rd, 8'($urandom), ($urandom_range(0, 15) == 0));
      if (int'(o_count) != q.size() || o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH)) bad++;
      if (q.size() > 0 && o_rd_data !== q[0]) bad++;
      if (o_overrun !== m_ovr || o_ovr_count !== (OVR_EN ? 8'(m_cnt) : 8'd0)) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL random got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_rst_mid();
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    pulse(8'h11); pulse(8'h22); pulse(8'h33);
    n_tests++; if (o_count !== 5'd3) begin n_fail++; $display("FAIL rstmid_pre got %0d exp 3", o_count); end
    #2 i_rst_n = 1'b0;
    #1;
    n_tests++; if (o_empty !== 1'b1 || o_count !== '0 || o_full !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got %b/%0d exp 1/0", o_empty, o_count); end
    model_reset();
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    n_tests++; if (o_empty !== 1'b1 || o_overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got %b/%b exp 1/0", o_empty, o_overrun); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overrun();
    test_saturate();
    test_wrap();
    test_random();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout exp finish before 2000000");
    $fatal(1);
  end

endmodule
